mem_req_issue: RTL

MEM_REQ_ISSUE -- requirements
Module: mem_req_issue

---
 rtl/mem_req_pkg.sv | 15 +
 rtl/mem_req_issue_sync_fifo.sv | 53 +++++
 rtl/mem_req_issue.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_req_pkg.sv
// Shared widths, default queue depths and the request word for the memory request issuer.
package mem_req_pkg;

    localparam int AW            = 4;
    localparam int DW            = 8;
    localparam int REQ_DEPTH_DEF = 4;
    localparam int RSP_DEPTH_DEF = 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_req_issue_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; a push at full is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_issue.sv
// Queues read/write requests and issues them in order to a one-cycle-latency memory,
// admitting a read only when its response is guaranteed a slot in the response buffer.
module mem_req_issue
    import mem_req_pkg::*;
#(
    parameter int REQ_DEPTH = REQ_DEPTH_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wen,
    output logic          mem_ren,
    input  logic [DW-1:0] mem_odata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy
);

    localparam int QCW = $clog2(REQ_DEPTH) + 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;

    req_t           req_in;
    req_t           head;
    logic [QCW-1:0] q_count;
    logic           q_push;
    logic           q_nonempty;
    logic           issue;
    logic           issue_rd;
    logic           rd_pend;

    logic [RCW-1:0] rsp_count;
    logic [DW-1:0]  rsp_head;
    logic           rsp_empty;
    logic           rsp_take;
    logic           rsp_push;
    logic           rsp_pop;
    logic [RCW:0]   rsp_occ;
    logic           rsp_room;

    assign req_in     = {req_we, req_addr, req_wdata};
    assign q_nonempty = (q_count != '0);
    assign req_ready  = !rst && (q_count != QCW'(REQ_DEPTH));
    assign q_push     = req_valid && req_ready;

    sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_q (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (issue),
        .wdata (req_in),
        .rdata (head),
        .count (q_count)
    );

    // Read data bypasses the buffer when it is empty so a response appears in the cycle mem_odata is valid.
    assign rsp_empty = (rsp_count == '0);
    assign rsp_valid = !rst && (!rsp_empty || rd_pend);
    assign rsp_data  = rst ? '0 : (!rsp_empty ? rsp_head : (rd_pend ? mem_odata : '0));
    assign rsp_take  = rsp_valid && rsp_ready;
    assign rsp_pop   = rsp_take && !rsp_empty;
    assign rsp_push  = rd_pend && !(rsp_empty && rsp_ready);

    sync_fifo #(.WIDTH(DW), .DEPTH(RSP_DEPTH)) u_rsp_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .pop   (rsp_pop),
        .wdata (mem_odata),
        .rdata (rsp_head),
        .count (rsp_count)
    );

    // Occupancy seen by a new read: buffered + in flight, minus whatever leaves this cycle.
    assign rsp_occ  = {1'b0, rsp_count} + {{RCW{1'b0}}, rd_pend} - {{RCW{1'b0}}, rsp_take};
    assign rsp_room = (rsp_occ < (RCW+1)'(RSP_DEPTH));

    assign issue    = !rst && q_nonempty && (head.we || rsp_room);
    assign issue_rd = issue && !head.we;
    assign busy     = !rst && (q_nonempty || rd_pend || !rsp_empty);

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wen  = 1'b0;
        mem_ren  = 1'b0;
        if (issue) begin
            mem_addr = head.addr;
            mem_wen  = head.we;
            mem_ren  = !head.we;
            mem_data = head.we ? head.wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= issue_rd;
        end
    end

endmodule
